// File: rtl/lcd_text_buffer.sv
// Character frame buffer for the HD44780 4-bit print engine: places a terminal-style
// byte stream at a tracked cursor and requests a refresh whenever the contents change.
module lcd_text_buffer #(
  parameter int         LINE_WIDTH   = 16,
  parameter int         NUM_LINES    = 4,
  parameter int         ADDR_BITS    = 6,
  parameter logic [7:0] FILL_CHAR    = 8'h20,
  parameter int         BUSY_HOLDOFF = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata,
  input  logic                 lcd_busy,
  output logic                 lcd_trg,
  output logic [1:0]           cursor_row,
  output logic [3:0]           cursor_col,
  output logic                 dirty,
  output logic                 o_dbg_in_state,
  output logic [1:0]           o_dbg_trg_state
);

  localparam int DEPTH = LINE_WIDTH * NUM_LINES;
  localparam int HW    = $clog2(BUSY_HOLDOFF) + 1;

  typedef enum logic {S_CLEAR = 1'b0, S_ACCEPT = 1'b1} in_state_t;
  typedef enum logic [1:0] {
    T_IDLE = 2'd0, T_PULSE = 2'd1, T_WAIT_BUSY = 2'd2, T_WAIT_IDLE = 2'd3
  } trg_state_t;

  // Handshake: a byte transfers at the posedge where in_valid and in_ready are both high;
  // in_ready depends only on registered state, never on in_valid.
  in_state_t            r_in_state, w_in_next;
  trg_state_t           r_trg_state, w_trg_next;
  logic [7:0]           r_mem [0:DEPTH-1];
  logic [ADDR_BITS-1:0] r_clr_cnt;
  logic [HW-1:0]        r_hold_cnt;
  logic [1:0]           r_row;
  logic [3:0]           r_col;
  logic                 r_dirty;
  logic                 r_trg;
  logic                 w_hs;
  logic                 w_wr_char;
  logic                 w_clr_done;
  logic                 w_trg_set;
  logic [ADDR_BITS-1:0] w_waddr;

  assign w_hs       = in_valid & in_ready;
  assign w_wr_char  = w_hs && (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_clr_done = (r_in_state == S_CLEAR) && (r_clr_cnt == ADDR_BITS'(DEPTH - 1));
  // Rows 1 and 3 live in the upper half so the engine prints L1,L3 then L2,L4.
  assign w_waddr    = {r_row[0], r_row[1], r_col};

  // ---------------- input FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_in_state <= S_CLEAR;
    else      r_in_state <= w_in_next;
  end

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      S_CLEAR:  if (w_clr_done) w_in_next = S_ACCEPT;
      S_ACCEPT: if (w_hs && in_data == 8'h0C) w_in_next = S_CLEAR;
      default:  w_in_next = S_CLEAR;
    endcase
  end

  always_comb begin
    in_ready       = (r_in_state == S_ACCEPT);
    o_dbg_in_state = r_in_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_cnt <= '0;
      r_row     <= 2'd0;
      r_col     <= 4'd0;
      r_dirty   <= 1'b0;
    end else begin
      if (r_in_state == S_CLEAR)       r_clr_cnt <= r_clr_cnt + 1'b1;
      else if (w_in_next == S_CLEAR)   r_clr_cnt <= '0;
      if (w_clr_done) begin
        r_row <= 2'd0;
        r_col <= 4'd0;
      end else if (w_wr_char) begin
        r_col <= r_col + 4'd1;
        if (r_col == 4'd15) r_row <= r_row + 2'd1;
      end else if (w_hs) begin
        case (in_data)
          8'h0A: begin r_col <= 4'd0; r_row <= r_row + 2'd1; end
          8'h0D: r_col <= 4'd0;
          8'h08: if (r_col != 4'd0) r_col <= r_col - 4'd1;
          default: ;
        endcase
      end
      // A change landing in the trigger cycle must survive the clear.
      if (w_wr_char || w_clr_done)     r_dirty <= 1'b1;
      else if (r_trg_state == T_PULSE) r_dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_in_state == S_CLEAR) r_mem[r_clr_cnt] <= FILL_CHAR;
    else if (w_wr_char)        r_mem[w_waddr]   <= in_data;
  end

  assign rdata      = r_mem[raddr];
  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign dirty      = r_dirty;

  // ---------------- trigger FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trg_state <= T_IDLE;
      r_trg       <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_trg_state <= w_trg_next;
      r_trg       <= w_trg_set;
      r_hold_cnt  <= (r_trg_state == T_WAIT_BUSY) ? r_hold_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_trg_next = r_trg_state;
    case (r_trg_state)
      T_IDLE:      if (r_dirty && !lcd_busy && r_in_state != S_CLEAR) w_trg_next = T_PULSE;
      T_PULSE:     w_trg_next = T_WAIT_BUSY;
      T_WAIT_BUSY: if (lcd_busy || r_hold_cnt == HW'(BUSY_HOLDOFF - 1)) w_trg_next = T_WAIT_IDLE;
      T_WAIT_IDLE: if (!lcd_busy) w_trg_next = T_IDLE;
      default:     w_trg_next = T_IDLE;
    endcase
  end

  always_comb begin
    w_trg_set       = (w_trg_next == T_PULSE);
    lcd_trg         = r_trg;
    o_dbg_trg_state = r_trg_state;
  end

endmodule
